// File: rtl/fanout_primitive_resp_l2_pkg.sv
// Shared L2 interconnect definitions: legal response latency range and the
// {valid, ID} entry carried down the response-ID latency pipeline.
package fanout_primitive_resp_l2_pkg;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 8;

  // IDs narrower than this are zero-extended into the entry.
  localparam int unsigned L2_ID_W_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic [L2_ID_W_MAX-1:0] id;
  } pipe_ent_t;

endpackage

// File: rtl/resp_id_pipe_l2.sv
// Response-ID latency pipeline: delays {accepted, ID} by exactly MEM_LATENCY
// cycles so the tail lines up with the target's read data.
// Ports: clk, rst (sync, active-high), in_valid_i/in_id_i (head entry),
//        tail_valid_o/tail_id_o (entry leaving the pipeline this cycle).
module resp_id_pipe_l2
  import fanout_primitive_resp_l2_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ID_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  input  logic [ID_WIDTH-1:0] in_id_i,
  output logic                tail_valid_o,
  output logic [ID_WIDTH-1:0] tail_id_o
);

  pipe_ent_t stage_q [MEM_LATENCY];
  pipe_ent_t stage_d [MEM_LATENCY];

  // Shift by one stage every cycle; idle cycles push an invalid entry.
  always_comb begin
    stage_d[0].valid = in_valid_i;
    stage_d[0].id    = L2_ID_W_MAX'(in_id_i);
    for (int i = 1; i < int'(MEM_LATENCY); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tail_valid_o = stage_q[MEM_LATENCY-1].valid;
  assign tail_id_o    = stage_q[MEM_LATENCY-1].id[ID_WIDTH-1:0];

  // Zero-extension bits above ID_WIDTH carry no information.
  if (ID_WIDTH < L2_ID_W_MAX) begin : g_id_pad
    logic unused_id_hi;
    assign unused_id_hi = ^stage_q[MEM_LATENCY-1].id[L2_ID_W_MAX-1:ID_WIDTH];
  end

endmodule

// File: rtl/fanout_primitive_resp_l2.sv
// Two-way response fan-out for an L2 target with fixed read latency.
// Accepted requests (req & gnt) are tracked by ID through a latency pipeline;
// the tail ID selects branch 0 (low ID half) or branch 1 (high ID half).
// Ports: clk, rst (sync, active-high); data_req_i/data_gnt_i/data_ID_i request
//        side; data_r_rdata_i read data; per-branch valid/rdata/ID outputs;
//        outstanding_o in-flight count; id_err_o sticky illegal-ID flag.
module fanout_primitive_resp_l2
  import fanout_primitive_resp_l2_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ID_SPLIT    = ID_WIDTH / 2,
  parameter int unsigned MEM_LATENCY = 1,
  localparam int unsigned CNT_W      = $clog2(MEM_LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_req_i,
  input  logic                  data_gnt_i,
  input  logic [ID_WIDTH-1:0]   data_ID_i,
  input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
  output logic                  data_r_valid0_o,
  output logic                  data_r_valid1_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata0_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata1_o,
  output logic [ID_WIDTH-1:0]   data_r_ID0_o,
  output logic [ID_WIDTH-1:0]   data_r_ID1_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  id_err_o
);

  logic                accept;
  logic                tail_valid;
  logic [ID_WIDTH-1:0] tail_id;
  logic                tail_lo;
  logic                tail_hi;
  logic                tail_bad;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  // A grant during reset is not an acceptance.
  assign accept = data_req_i & data_gnt_i & ~rst;

  resp_id_pipe_l2 #(
    .MEM_LATENCY (MEM_LATENCY),
    .ID_WIDTH    (ID_WIDTH)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .in_valid_i   (accept),
    .in_id_i      (data_ID_i),
    .tail_valid_o (tail_valid),
    .tail_id_o    (tail_id)
  );

  // Route on ID half ownership; both halves or neither is an illegal ID.
  assign tail_lo  = |tail_id[ID_SPLIT-1:0];
  assign tail_hi  = |tail_id[ID_WIDTH-1:ID_SPLIT];
  assign tail_bad = tail_valid & (tail_lo == tail_hi);

  assign data_r_valid0_o = tail_valid & tail_lo & ~tail_hi;
  assign data_r_valid1_o = tail_valid & tail_hi & ~tail_lo;
  assign data_r_rdata0_o = data_r_rdata_i;
  assign data_r_rdata1_o = data_r_rdata_i;
  assign data_r_ID0_o    = tail_id;
  assign data_r_ID1_o    = tail_id;

  // Every tail valid retires one entry, including illegal-ID ones.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | tail_bad;
    unique case ({accept, tail_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign id_err_o      = err_q;

endmodule

// File: tb/tb_fanout_primitive_resp_l2.sv
// Bench for fanout_primitive_resp_l2: four instances (MEM_LATENCY 1..4) share
// one stimulus stream; each is compared against a queue-of-scheduled-responses
// model every cycle.
module tb_fanout_primitive_resp_l2;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [15:0] id;
  logic [63:0] rdata;

  logic        v0   [NI];
  logic        v1   [NI];
  logic [63:0] rd0  [NI];
  logic [63:0] rd1  [NI];
  logic [15:0] id0  [NI];
  logic [15:0] id1  [NI];
  logic [2:0]  outs [NI];
  logic        err  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(g+2)-1:0] out_w;
    fanout_primitive_resp_l2 #(
      .ID_WIDTH    (16),
      .DATA_WIDTH  (64),
      .ID_SPLIT    (8),
      .MEM_LATENCY (g + 1)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .data_req_i      (req),
      .data_gnt_i      (gnt),
      .data_ID_i       (id),
      .data_r_rdata_i  (rdata),
      .data_r_valid0_o (v0[g]),
      .data_r_valid1_o (v1[g]),
      .data_r_rdata0_o (rd0[g]),
      .data_r_rdata1_o (rd1[g]),
      .data_r_ID0_o    (id0[g]),
      .data_r_ID1_o    (id1[g]),
      .outstanding_o   (out_w),
      .id_err_o        (err[g])
    );
    assign outs[g] = 3'(out_w);
  end

  // Reference model: each accepted request is scheduled for cycle accept+L.
  typedef struct {
    int          due;
    logic [15:0] id;
  } ent_t;

  ent_t pend  [NI][$];
  bit   err_m [NI];
  int   cyc_n;
  bit   armed;
  int   peak2;
  int   n_chk;
  int   n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic string tg(input string s, input int i);
    return $sformatf("%s_L%0d", s, i + 1);
  endfunction

  // One clock cycle: drive inputs, compare all instances, advance the model.
  task automatic cyc(input bit r, input bit rq, input bit gt,
                     input logic [15:0] i_id, input logic [63:0] d);
    ent_t e;
    bit   found;
    bit   lo, hi;
    int   n_exp;
    @(posedge clk);
    #1;
    rst = r; req = rq; gnt = gt; id = i_id; rdata = d;
    #1;
    for (int i = 0; i < NI; i++) begin
      found = 1'b0;
      e.due = 0;
      e.id  = '0;
      n_exp = pend[i].size();
      if (n_exp > 0 && pend[i][0].due == cyc_n) begin
        found = 1'b1;
        e = pend[i].pop_front();
      end
      lo = (e.id & 16'h00FF) != 16'h0;
      hi = (e.id & 16'hFF00) != 16'h0;
      if (armed) begin
        check(tg("valid0", i), 64'(v0[i]), 64'(found && lo && !hi));
        check(tg("valid1", i), 64'(v1[i]), 64'(found && hi && !lo));
        check(tg("outstanding", i), 64'(outs[i]), 64'(n_exp));
        check(tg("id_err", i), 64'(err[i]), 64'(err_m[i]));
        check(tg("rdata0", i), rd0[i], d);
        check(tg("rdata1", i), rd1[i], d);
        if (found) begin
          check(tg("id0", i), 64'(id0[i]), 64'(e.id));
          check(tg("id1", i), 64'(id1[i]), 64'(e.id));
        end
      end
      if (r) begin
        pend[i].delete();
        err_m[i] = 1'b0;
      end else begin
        if (found && (lo == hi)) err_m[i] = 1'b1;
        if (rq && gt) pend[i].push_back('{due: cyc_n + i + 1, id: i_id});
      end
    end
    if (armed && int'(outs[2]) > peak2) peak2 = int'(outs[2]);
    armed = 1'b1;
    cyc_n++;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] rnd_id();
    logic [7:0] b;
    b = 8'($urandom_range(1, 255));
    case ($urandom_range(0, 19))
      0, 1, 2, 3, 4:      return 16'(16'h1 << $urandom_range(0, 7));
      5, 6, 7, 8, 9:      return 16'(16'h1 << $urandom_range(8, 15));
      10, 11, 12, 13:     return {8'h00, b};
      14, 15, 16, 17:     return {b, 8'h00};
      18:                 return 16'h0000;
      default:            return {b, 8'($urandom_range(1, 255))};
    endcase
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 16'h0, rnd64());
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 16'h0, rnd64());
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; gnt = 1'b0; id = '0; rdata = '0;
    n_chk = 0; n_bad = 0; cyc_n = 0; armed = 1'b0; peak2 = 0;
    for (int i = 0; i < NI; i++) err_m[i] = 1'b0;

    do_reset();
    do_reset();
    idle(2);

    // Single low-half response
    cyc(1'b0, 1'b1, 1'b1, 16'h0001, rnd64());
    idle(6);

    // Back-to-back, high branch then low branch
    do_reset();
    peak2 = 0;
    cyc(1'b0, 1'b1, 1'b1, 16'h0100, rnd64());
    cyc(1'b0, 1'b1, 1'b1, 16'h0002, rnd64());
    idle(6);
    check("peak_outstanding_L3", 64'(peak2), 64'd2);

    // Request without grant
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 16'h0001, rnd64());
    idle(6);
    for (int i = 0; i < NI; i++) check(tg("nognt_out", i), 64'(outs[i]), 64'd0);

    // Illegal ID sets a sticky error
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 16'h0101, rnd64());
    idle(105);
    for (int i = 0; i < NI; i++) check(tg("sticky_err", i), 64'(err[i]), 64'd1);

    // Reset with requests in flight
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 16'h0004, rnd64());
    cyc(1'b0, 1'b1, 1'b1, 16'h0400, rnd64());
    cyc(1'b1, 1'b1, 1'b1, 16'h0008, rnd64());
    idle(8);
    for (int i = 0; i < NI; i++) check(tg("flush_out", i), 64'(outs[i]), 64'd0);

    // Continuous acceptance
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b1, 1'b1, (k % 2 == 0) ? 16'h0010 : 16'h2000, rnd64());
      if (k >= 4) check("steady_out_L2", 64'(outs[1]), 64'd2);
    end
    idle(6);

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) != 0), rnd_id(), rnd64());
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fanout_primitive_resp_l2.md
FANOUT_PRIMITIVE_RESP_L2 -- requirements
Module: fanout_primitive_resp_l2

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 16, meaning the one-hot initiator ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, meaning the read data width.
REQ-003 SHALL have parameter ID_SPLIT, default ID_WIDTH/2, meaning the lowest ID bit owned by branch 1.
REQ-004 SHALL have parameter MEM_LATENCY, default 1, legal 1..8, meaning cycles from accepted request to read data valid.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port data_req_i, input, 1, the request observed at the target side.
REQ-008 SHALL have port data_gnt_i, input, 1, the grant from the target.
REQ-009 SHALL have port data_ID_i, input, ID_WIDTH, the ID of the request.
REQ-010 SHALL have port data_r_rdata_i, input, DATA_WIDTH, the read data from the target, valid MEM_LATENCY cycles after acceptance.
REQ-011 SHALL have ports data_r_valid0_o and data_r_valid1_o, output, 1 each, the response valid for branch 0 and branch 1.
REQ-012 SHALL have ports data_r_rdata0_o and data_r_rdata1_o, output, DATA_WIDTH each, the response data per branch.
REQ-013 SHALL have ports data_r_ID0_o and data_r_ID1_o, output, ID_WIDTH each, the response ID per branch.
REQ-014 SHALL have port outstanding_o, output, $clog2(MEM_LATENCY+1), the count of accepted requests not yet responded.
REQ-015 SHALL have port id_err_o, output, 1, a sticky flag for an illegal ID.

Function
REQ-016 SHALL treat a request as accepted in a cycle where data_req_i & data_gnt_i = 1.
REQ-017 SHALL push {valid, ID} of every cycle into a MEM_LATENCY-deep shift pipeline; valid = acceptance.
REQ-018 SHALL assert the pipeline tail valid exactly MEM_LATENCY cycles after acceptance; back-to-back acceptances produce back-to-back responses with no bubble.
REQ-019 SHALL route by the tail ID: any bit in [ID_SPLIT-1:0] set and none in [ID_WIDTH-1:ID_SPLIT] sets data_r_valid0_o; the reverse sets data_r_valid1_o.
REQ-020 SHALL never assert data_r_valid0_o and data_r_valid1_o in the same cycle.
REQ-021 SHALL drive data_r_rdata_i combinationally to both rdata outputs, with no added latency on data.
REQ-022 SHALL drive the tail ID to both ID outputs in every cycle.
REQ-023 SHALL handle a tail ID with bits in both halves, or an all-zero ID with tail valid, as follows:
- assert neither valid;
- set id_err_o on the next cycle;
- hold id_err_o until reset.
REQ-024 SHALL update outstanding_o as follows:
- +1 on acceptance;
- -1 on tail valid, including the error case;
- unchanged when both occur in the same cycle.
REQ-025 SHALL keep outstanding_o within 0..MEM_LATENCY; no wrap-around is possible by construction.
REQ-026 SHALL have no ready/backpressure on the response side; initiators always accept responses.

Reset
REQ-027 SHALL, with rst=1 at a clk edge, clear all pipeline valids, outstanding_o and id_err_o to 0.
REQ-028 SHALL drop any request in flight at reset mid-operation; its response SHALL never appear.
REQ-029 SHALL ignore acceptance in a cycle where rst=1.
REQ-030 SHALL hold, after reset, data_r_valid0_o=0, data_r_valid1_o=0, outstanding_o=0 and id_err_o=0.

Structure
REQ-031 SHALL place the MEM_LATENCY legal range and the pipeline entry struct {valid, ID} in the shared L2 interconnect package.
REQ-032 SHALL implement the latency pipeline as sub-module resp_id_pipe_l2, parameterised by MEM_LATENCY and ID_WIDTH.
REQ-033 SHALL keep the routing decode and the counter in the top module.

Verification
REQ-034 SHALL cover: MEM_LATENCY=1, ID=16'h0001 accepted at cycle 0 -> data_r_valid0_o=1 at cycle 1 with data_r_ID0_o=16'h0001, and outstanding_o goes 1 then 0.
REQ-035 SHALL cover: MEM_LATENCY=3, ID=16'h0100 then ID=16'h0002 accepted back-to-back -> valid1 at cycle 3 and valid0 at cycle 4, with outstanding_o peaking at 2.
REQ-036 SHALL cover: req=1 with gnt=0 for 5 cycles -> no response valid and outstanding_o=0.
REQ-037 SHALL cover: ID=16'h0101 accepted -> neither valid after MEM_LATENCY, id_err_o=1 from the following cycle, and id_err_o still 1 100 cycles later.
REQ-038 SHALL cover: MEM_LATENCY=4, three acceptances, then rst=1 on cycle 2 -> no valid ever appears and outstanding_o=0 after reset.
REQ-039 SHALL cover: MEM_LATENCY=2, continuous acceptance for 20 cycles -> outstanding_o steady at 2 and one valid per cycle.
